// File: rtl/iob_reg_bank.sv
// Bank of WIDTH registered bidirectional pads with an input synchroniser,
// edge detection on the synchronised input and a warm-up gate on the pulses.
//
// state  | meaning
// WARMUP | sync chain still carries reset values; edge pulses suppressed
// ARMED  | edge pulses enabled; held until the next reset
module iob_reg_bank #(
   parameter int               WIDTH    = 8,
   parameter int               IN_SYNC  = 2,
   parameter bit               OUT_REG  = 1'b1,
   parameter bit               OE_REG   = 1'b1,
   parameter logic [WIDTH-1:0] OUT_INIT = '0
) (
   input  logic             C,
   input  logic             RD,
   input  logic             CE,
   inout  wire  [WIDTH-1:0] PAD,
   input  logic [WIDTH-1:0] O,
   input  logic [WIDTH-1:0] EN,
   output logic [WIDTH-1:0] I,
   output logic [WIDTH-1:0] I_RISE,
   output logic [WIDTH-1:0] I_FALL
);

   localparam int CW = $clog2(IN_SYNC + 2);

   typedef enum logic {WARMUP, ARMED} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             armed;
   logic [WIDTH-1:0] o_q, oe_q, o_drv, oe_drv, h;

   always_ff @(posedge C or negedge RD) begin
      if (!RD) begin
         o_q  <= OUT_INIT;
         oe_q <= '0;
      end else if (CE) begin
         o_q  <= O;
         oe_q <= EN;
      end
   end

   assign o_drv  = OUT_REG ? o_q  : O;
   assign oe_drv = OE_REG  ? oe_q : EN;

   for (genvar k = 0; k < WIDTH; k++) begin : g_pad
      assign PAD[k] = oe_drv[k] ? o_drv[k] : 1'bz;
   end

   // Input path is free-running; CE only gates the output side.
   if (IN_SYNC == 0) begin : g_nosync
      assign I = PAD;
   end else begin : g_sync
      logic [WIDTH-1:0] s [IN_SYNC];
      always_ff @(posedge C or negedge RD) begin
         if (!RD) begin
            for (int n = 0; n < IN_SYNC; n++) s[n] <= '0;
         end else begin
            s[0] <= PAD;
            for (int n = 1; n < IN_SYNC; n++) s[n] <= s[n-1];
         end
      end
      assign I = s[IN_SYNC-1];
   end

   always_ff @(posedge C or negedge RD) begin
      if (!RD) h <= '0;
      else     h <= I;
   end

   assign I_RISE = I & ~h & {WIDTH{armed}};
   assign I_FALL = ~I & h & {WIDTH{armed}};

   always_ff @(posedge C or negedge RD) begin
      if (!RD) begin
         state <= WARMUP;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Arm one cycle after I is valid so h also holds a real sample.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      armed    = 1'b0;
      case (state)
         WARMUP: begin
            if (cnt != '1) cnt_nx = cnt + CW'(1);
            if (cnt == CW'(IN_SYNC)) state_nx = ARMED;
         end
         ARMED: armed = 1'b1;
         default: state_nx = WARMUP;
      endcase
   end

endmodule

// File: tb/tb_iob_reg_bank.sv
// Randomised bench for iob_reg_bank against a sample-history model of the pads.
module tb_iob_reg_bank;
   localparam int WIDTH   = 8;
   localparam int IN_SYNC = 2;

   logic             C = 1'b0;
   logic             RD = 1'b0;
   logic             CE = 1'b0;
   logic [WIDTH-1:0] O = '0, EN = '0, ext = '0;
   wire  [WIDTH-1:0] PAD;
   logic [WIDTH-1:0] I, I_RISE, I_FALL;

   // Model: expected driver state plus every pad value sampled since reset.
   logic [WIDTH-1:0] m_o = '0, m_oe = '0;
   logic [WIDTH-1:0] samp [$];
   int               n_cmp = 0, n_bad = 0;

   always #5 C = ~C;

   iob_reg_bank #(.WIDTH(WIDTH), .IN_SYNC(IN_SYNC)) dut (
      .C(C), .RD(RD), .CE(CE), .PAD(PAD), .O(O), .EN(EN),
      .I(I), .I_RISE(I_RISE), .I_FALL(I_FALL)
   );

   // Bench drives only pads the DUT should leave high-Z, so stray drive shows up.
   for (genvar k = 0; k < WIDTH; k++) begin : g_ext
      assign PAD[k] = m_oe[k] ? 1'bz : ext[k];
   end

   always @(posedge C or negedge RD) begin
      if (!RD) begin
         m_o  <= '0;
         m_oe <= '0;
         samp.delete();
      end else begin
         samp.push_back((m_oe & m_o) | (~m_oe & ext));
         if (CE) begin
            m_o  <= O;
            m_oe <= EN;
         end
      end
   end

   function automatic logic [WIDTH-1:0] i_after(int n);
      if (n < IN_SYNC || n - IN_SYNC >= samp.size()) return '0;
      return samp[n - IN_SYNC];
   endfunction

   task automatic chk(string tag, logic [WIDTH-1:0] got, logic [WIDTH-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      int n;
      logic [WIDTH-1:0] ei, eh, arm;
      n   = samp.size();
      ei  = i_after(n);
      eh  = i_after(n - 1);
      arm = (RD && n >= IN_SYNC + 1) ? '1 : '0;
      chk("pad",  PAD,    (m_oe & m_o) | (~m_oe & ext));
      chk("i",    I,      ei);
      chk("rise", I_RISE, ei & ~eh & arm);
      chk("fall", I_FALL, ~ei & eh & arm);
   endtask

   task automatic cyc();
      @(posedge C);
      @(negedge C);
      check_all();
   endtask

   initial begin
      // T1: reset holds pads high-Z even with EN/CE asserted
      RD = 1'b0; EN = 8'hFF; O = 8'hA5; CE = 1'b1; ext = 8'h00;
      repeat (2) cyc();
      chk("t1_pad_z", PAD, 8'h00);
      chk("t1_i", I, 8'h00);
      RD = 1'b1;
      cyc();
      chk("t1_pad", PAD, 8'hA5);

      // T2: CE=0 holds the output registers
      CE = 1'b0; O = 8'h00;
      cyc();
      O = 8'hFF;
      cyc();
      chk("t2_hold", PAD, 8'hA5);
      CE = 1'b1;
      cyc();
      chk("t2_load", PAD, 8'hFF);

      // T3: sync latency and single rise pulse
      EN = 8'h00; ext = 8'h00;
      repeat (4) cyc();
      ext = 8'h08;
      cyc();
      chk("t3_i_early", I, 8'h00);
      cyc();
      chk("t3_i", I, 8'h08);
      chk("t3_rise", I_RISE, 8'h08);
      cyc();
      chk("t3_rise_end", I_RISE, 8'h00);

      // T5: one-cycle glitch gives rise then fall
      ext = 8'h09;
      cyc();
      ext = 8'h08;
      cyc();
      chk("t5_rise", I_RISE, 8'h01);
      cyc();
      chk("t5_fall", I_FALL, 8'h01);

      // T4: pads high through reset release produce no rise
      RD = 1'b0; ext = 8'hFF;
      repeat (2) cyc();
      RD = 1'b1;
      for (int c = 0; c < 5; c++) begin
         cyc();
         chk("t4_rise", I_RISE, 8'h00);
      end
      chk("t4_i", I, 8'hFF);

      // T6: async reset between edges while driving
      EN = 8'hFF; O = 8'h5A; ext = 8'h00;
      repeat (2) cyc();
      chk("t6_drive", PAD, 8'h5A);
      #2 RD = 1'b0;
      #1 chk("t6_pad_z", PAD, 8'h00);
      @(negedge C);
      RD = 1'b1; EN = 8'h00; ext = 8'hF0;
      for (int c = 0; c < IN_SYNC + 2; c++) begin
         cyc();
         if (c < IN_SYNC) chk("t6_warm", I_RISE | I_FALL, 8'h00);
      end

      // Random traffic with occasional async resets
      for (int c = 0; c < 400; c++) begin
         O   = WIDTH'($urandom);
         EN  = WIDTH'($urandom);
         ext = WIDTH'($urandom);
         CE  = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) begin
            #2 RD = 1'b0;
            #1 chk("rnd_rst_pad", PAD, ext);
            @(negedge C);
            RD = 1'b1;
         end
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
